// File: rtl/regwr_arbiter.sv
// regwr_arbiter: shares the register-file write port between pipeline (A) and multi-cycle (B) writeback,
// with a starvation bound for B and a fully registered write port.
module regwr_arbiter #(
  parameter int WORD = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [4:0]      a_reg,
  input  logic [WORD-1:0] a_data,
  input  logic            a_link,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_reg,
  input  logic [WORD-1:0] b_data,
  input  logic            b_link,
  output logic            RegWrite,
  output logic            WRegLoc,
  output logic [4:0]      w_reg,
  output logic [WORD-1:0] w_data,
  output logic            b_forced
);
  logic [3:0]      starve_q, starve_d;
  logic            regwrite_q, regwrite_d, wregloc_q, wregloc_d;
  logic [4:0]      w_reg_q, w_reg_d;
  logic [WORD-1:0] w_data_q, w_data_d;
  logic            force_c, accept, sel_link;
  logic [4:0]      sel_reg;
  logic [WORD-1:0] sel_data;
  // rst_n is active-high despite its name: ready is suppressed for the whole reset window
  assign force_c  = starve_q == 4'(STARVE_LIMIT);
  assign b_ready  = !rst_n && b_valid && (force_c || !a_valid);
  assign a_ready  = !rst_n && a_valid && !b_ready;
  assign b_forced = b_ready && force_c && a_valid;
  always_comb begin
    accept     = a_ready || b_ready;
    sel_reg    = b_ready ? b_reg : a_reg;
    sel_data   = b_ready ? b_data : a_data;
    sel_link   = b_ready ? b_link : a_link;
    starve_d   = (b_valid && !b_ready) ? (force_c ? starve_q : starve_q + 4'd1) : 4'd0;
    regwrite_d = accept && (sel_link || sel_reg != 5'd31);
    wregloc_d  = accept && sel_link;
    w_reg_d    = accept ? sel_reg : w_reg_q;
    w_data_d   = accept ? sel_data : w_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      starve_q   <= '0;
      regwrite_q <= 1'b0;
      wregloc_q  <= 1'b0;
      w_reg_q    <= '0;
      w_data_q   <= '0;
    end else begin
      starve_q   <= starve_d;
      regwrite_q <= regwrite_d;
      wregloc_q  <= wregloc_d;
      w_reg_q    <= w_reg_d;
      w_data_q   <= w_data_d;
    end
  end
  assign RegWrite = regwrite_q;
  assign WRegLoc  = wregloc_q;
  assign w_reg    = w_reg_q;
  assign w_data   = w_data_q;
endmodule
